// File: rtl/prog_sequencer.sv
// prog_sequencer: feeds the mv/mvi/add/sub processor from an internal program memory.
// Define SEQ_STEP_EN to add a HOLD state that waits for Step after each completed instruction.
module prog_sequencer #(
  parameter int AW   = 4,
  parameter int WDOG = 4
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          LdEn,
  input  logic [AW-1:0] LdAddr,
  input  logic [14:0]   LdWord,
  input  logic          Start,
  input  logic [AW-1:0] StartAddr,
  input  logic          Abort,
  input  logic          Step,
  input  logic          ProcDone,
  output logic          w,
  output logic [1:0]    F,
  output logic [1:0]    Rx,
  output logic [1:0]    Ry,
  output logic [7:0]    Data,
  output logic [AW-1:0] PC,
  output logic          Busy,
  output logic          Halted,
  output logic          Error,
  output logic [7:0]    InstrCount
);

  // state | meaning
  // IDLE  | waiting for Start; program memory writable
  // ISSUE | w=1 for one cycle; word was registered on entry
  // WAIT  | word held, waiting for ProcDone; watchdog running
  // DRAIN | abort latched, waiting for the in-flight ProcDone
  // ERROR | watchdog expired; memory writable; Start restarts
  // HOLD  | PC already advanced, waiting for Step (SEQ_STEP_EN only)
  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DRAIN,
    S_ERROR
`ifdef SEQ_STEP_EN
    , S_HOLD
`endif
  } state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   pc_nxt;
  logic [14:0]     word_q;
  logic [14:0]     mem [2**AW];
  logic [3:0]      wd_cnt;
  logic            wd_last;
  logic            load_ok;

  assign wd_last = (wd_cnt + 4'd1) == 4'(WDOG);
  assign load_ok = (state == S_IDLE) || (state == S_ERROR);

`ifndef SEQ_STEP_EN
  logic unused_step;
  assign unused_step = Step;
`endif

  always_ff @(posedge Clock) begin
    if (LdEn && load_ok)
      mem[LdAddr] <= LdWord;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= S_IDLE;
      PC         <= '0;
      word_q     <= '0;
      wd_cnt     <= '0;
      Halted     <= 1'b0;
      InstrCount <= '0;
    end else begin
      state <= state_nxt;
      PC    <= pc_nxt;
      // Fields are captured on the edge entering ISSUE and held until the next issue.
      if (state_nxt == S_ISSUE)
        word_q <= mem[pc_nxt];
      if (load_ok && state_nxt == S_ISSUE) begin
        Halted     <= 1'b0;
        InstrCount <= '0;
      end
      if ((state == S_WAIT || state == S_DRAIN) && ProcDone)
        InstrCount <= InstrCount + 8'd1;
      if (state == S_WAIT && ProcDone && !Abort && word_q[14])
        Halted <= 1'b1;
      if (state == S_ISSUE)
        wd_cnt <= '0;
      else if (state == S_WAIT || state == S_DRAIN)
        wd_cnt <= wd_cnt + 4'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = PC;
    case (state)
      S_IDLE, S_ERROR: begin
        if (Start && !Abort) begin
          state_nxt = S_ISSUE;
          pc_nxt    = StartAddr;
        end
      end
      S_ISSUE: state_nxt = Abort ? S_DRAIN : S_WAIT;
      S_WAIT: begin
        if (ProcDone) begin
          if (Abort || word_q[14]) begin
            state_nxt = S_IDLE;
          end else begin
            pc_nxt = PC + AW'(1);
`ifdef SEQ_STEP_EN
            state_nxt = S_HOLD;
`else
            state_nxt = S_ISSUE;
`endif
          end
        end else if (wd_last) begin
          state_nxt = S_ERROR;
        end else if (Abort) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (ProcDone)
          state_nxt = S_IDLE;
        else if (wd_last)
          state_nxt = S_ERROR;
      end
`ifdef SEQ_STEP_EN
      S_HOLD: begin
        if (Abort)
          state_nxt = S_IDLE;
        else if (Step)
          state_nxt = S_ISSUE;
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w     = (state == S_ISSUE);
    Error = (state == S_ERROR);
    Busy  = (state == S_ISSUE) || (state == S_WAIT) || (state == S_DRAIN);
`ifdef SEQ_STEP_EN
    if (state == S_HOLD)
      Busy = 1'b1;
`endif
  end

  assign F    = word_q[13:12];
  assign Rx   = word_q[11:10];
  assign Ry   = word_q[9:8];
  assign Data = word_q[7:0];

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed bench for prog_sequencer: a small processor model answers w with Done,
// and a second AW=2 instance exercises PC wrap.
module tb_prog_sequencer;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        LdEn;
  logic [3:0]  LdAddr;
  logic [14:0] LdWord;
  logic        Start;
  logic [3:0]  StartAddr;
  logic        Abort;
  logic        Step;
  logic        ProcDone;
  logic        w;
  logic [1:0]  F, Rx, Ry;
  logic [7:0]  Data;
  logic [3:0]  PC;
  logic        Busy, Halted, Error;
  logic [7:0]  InstrCount;

  logic        b_LdEn;
  logic [1:0]  b_LdAddr;
  logic [14:0] b_LdWord;
  logic        b_Start;
  logic [1:0]  b_StartAddr;
  logic        b_Abort;
  logic        b_done;
  logic        b_w;
  logic [1:0]  b_F, b_Rx, b_Ry;
  logic [7:0]  b_Data;
  logic [1:0]  b_PC;
  logic        b_Busy, b_Halted, b_Error;
  logic [7:0]  b_InstrCount;

  int checks = 0;
  int errors = 0;

  always #5 Clock = ~Clock;

  prog_sequencer #(.AW(4), .WDOG(4)) dut (
    .Clock(Clock), .Reset(Reset), .LdEn(LdEn), .LdAddr(LdAddr), .LdWord(LdWord),
    .Start(Start), .StartAddr(StartAddr), .Abort(Abort), .Step(Step), .ProcDone(ProcDone),
    .w(w), .F(F), .Rx(Rx), .Ry(Ry), .Data(Data), .PC(PC), .Busy(Busy),
    .Halted(Halted), .Error(Error), .InstrCount(InstrCount)
  );

  prog_sequencer #(.AW(2), .WDOG(4)) dut2 (
    .Clock(Clock), .Reset(Reset), .LdEn(b_LdEn), .LdAddr(b_LdAddr), .LdWord(b_LdWord),
    .Start(b_Start), .StartAddr(b_StartAddr), .Abort(b_Abort), .Step(1'b0), .ProcDone(b_done),
    .w(b_w), .F(b_F), .Rx(b_Rx), .Ry(b_Ry), .Data(b_Data), .PC(b_PC), .Busy(b_Busy),
    .Halted(b_Halted), .Error(b_Error), .InstrCount(b_InstrCount)
  );

  // Processor model: Done in T1 for mv/mvi, in T3 for add/sub.
  logic       pd_kill = 1'b0;
  logic [1:0] pt;
  logic [1:0] pf, prx, pry;
  logic [7:0] pdata;
  logic [7:0] R [4];

  assign ProcDone = !pd_kill && ((pt == 2'd1 && !pf[1]) || pt == 2'd3);

  always @(posedge Clock) begin
    if (Reset) begin
      pt <= 2'd0;
    end else if (pt == 2'd0) begin
      if (w) begin
        pt <= 2'd1; pf <= F; prx <= Rx; pry <= Ry; pdata <= Data;
      end
    end else if (ProcDone) begin
      pt <= 2'd0;
      case (pf)
        2'b00: R[prx] <= R[pry];
        2'b01: R[prx] <= pdata;
        2'b10: R[prx] <= R[prx] + R[pry];
        default: R[prx] <= R[prx] - R[pry];
      endcase
    end else begin
      pt <= pt + 2'd1;
    end
  end

  always @(posedge Clock) b_done <= Reset ? 1'b0 : b_w;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic load(input logic [3:0] a, input logic [14:0] wd);
    LdEn = 1'b1; LdAddr = a; LdWord = wd;
    tick();
    LdEn = 1'b0;
  endtask

  task automatic start(input logic [3:0] a);
    Start = 1'b1; StartAddr = a;
    tick();
    Start = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    tick(); tick();
    Reset = 1'b0;
    checks++; if (w !== 1'b0) begin errors++; $display("FAIL reset_w got %b want 0", w); end
    checks++; if ({F, Rx, Ry, Data} !== 14'd0) begin errors++; $display("FAIL reset_fields got %h want 0", {F, Rx, Ry, Data}); end
    checks++; if (PC !== 4'd0) begin errors++; $display("FAIL reset_pc got %0d want 0", PC); end
    checks++; if ({Busy, Halted, Error} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {Busy, Halted, Error}); end
    checks++; if (InstrCount !== 8'd0) begin errors++; $display("FAIL reset_count got %0d want 0", InstrCount); end
  endtask

  task automatic test_stop_run();
    int wcnt = 0;
    logic w0 = 1'b0, w2 = 1'b0;
    logic [7:0] d0 = 8'h00, d1 = 8'h00;
    load(4'd0, {1'b0, 2'b01, 2'b01, 2'b00, 8'h2A});
    load(4'd1, {1'b1, 2'b01, 2'b10, 2'b00, 8'h05});
    start(4'd0);
    for (int c = 0; c < 8; c++) begin
      if (w) wcnt++;
      if (c == 0) begin
        w0 = w; d0 = Data;
        LdEn = 1'b1; LdAddr = 4'd1; LdWord = {1'b0, 2'b01, 2'b10, 2'b00, 8'h99};
      end
      if (c == 1) begin d1 = Data; LdEn = 1'b0; end
      if (c == 2) w2 = w;
      tick();
    end
    checks++; if (wcnt !== 2) begin errors++; $display("FAIL stop_wpulses got %0d want 2", wcnt); end
    checks++; if ({w0, w2} !== 2'b11) begin errors++; $display("FAIL stop_wspacing got %b want 11", {w0, w2}); end
    checks++; if ({d0, d1} !== 16'h2A2A) begin errors++; $display("FAIL stop_datahold got %h want 2a2a", {d0, d1}); end
    checks++; if (Halted !== 1'b1) begin errors++; $display("FAIL stop_halted got %b want 1", Halted); end
    checks++; if (PC !== 4'd1) begin errors++; $display("FAIL stop_pc got %0d want 1", PC); end
    checks++; if (InstrCount !== 8'd2) begin errors++; $display("FAIL stop_count got %0d want 2", InstrCount); end
    checks++; if ({R[1], R[2]} !== 16'h2A05) begin errors++; $display("FAIL stop_regs got %h want 2a05", {R[1], R[2]}); end
  endtask

  task automatic test_add_run();
    int busy_n = 0, wcnt = 0, fcnt = 0;
    load(4'd2, {1'b0, 2'b01, 2'b00, 2'b00, 8'd3});
    load(4'd3, {1'b0, 2'b01, 2'b01, 2'b00, 8'd4});
    load(4'd4, {1'b1, 2'b10, 2'b00, 2'b01, 8'd0});
    start(4'd2);
    for (int c = 0; c < 40 && Busy; c++) begin
      busy_n++;
      if (w) wcnt++;
      if (F == 2'b10) fcnt++;
      tick();
    end
    checks++; if (busy_n !== 8) begin errors++; $display("FAIL add_runlen got %0d want 8", busy_n); end
    checks++; if (wcnt !== 3) begin errors++; $display("FAIL add_wpulses got %0d want 3", wcnt); end
    checks++; if (fcnt !== 4) begin errors++; $display("FAIL add_cycles got %0d want 4", fcnt); end
    checks++; if (R[0] !== 8'd7) begin errors++; $display("FAIL add_r0 got %0d want 7", R[0]); end
    checks++; if (InstrCount !== 8'd3) begin errors++; $display("FAIL add_count got %0d want 3", InstrCount); end
    checks++; if ({Halted, PC} !== {1'b1, 4'd4}) begin errors++; $display("FAIL add_end got %b/%0d want 1/4", Halted, PC); end
  endtask

  task automatic test_abort();
    int wcnt = 0;
    load(4'd6, {1'b0, 2'b10, 2'b00, 2'b01, 8'd0});
    load(4'd7, {1'b0, 2'b01, 2'b10, 2'b00, 8'hEE});
    Start = 1'b1; Abort = 1'b1; StartAddr = 4'd6;
    tick();
    Start = 1'b0; Abort = 1'b0;
    checks++; if ({Busy, w} !== 2'b00) begin errors++; $display("FAIL abort_start_tie got %b want 00", {Busy, w}); end
    start(4'd6);
    tick(); tick();
    Abort = 1'b1;
    tick();
    Abort = 1'b0;
    checks++; if ({Busy, w} !== 2'b10) begin errors++; $display("FAIL abort_drain got %b want 10", {Busy, w}); end
    for (int c = 0; c < 8; c++) begin
      if (w) wcnt++;
      tick();
    end
    checks++; if (wcnt !== 0) begin errors++; $display("FAIL abort_nopulse got %0d want 0", wcnt); end
    checks++; if ({Busy, Halted} !== 2'b00) begin errors++; $display("FAIL abort_flags got %b want 00", {Busy, Halted}); end
    checks++; if (InstrCount !== 8'd1) begin errors++; $display("FAIL abort_count got %0d want 1", InstrCount); end
    checks++; if (PC !== 4'd6) begin errors++; $display("FAIL abort_pc got %0d want 6", PC); end
    checks++; if ({R[0], R[2]} !== {8'd11, 8'd5}) begin errors++; $display("FAIL abort_regs got %h want 0b05", {R[0], R[2]}); end
  endtask

  task automatic test_watchdog();
    pd_kill = 1'b1;
    load(4'd8, {1'b0, 2'b01, 2'b11, 2'b00, 8'h11});
    start(4'd8);
    tick(); tick(); tick(); tick();
    checks++; if ({Error, Busy} !== 2'b01) begin errors++; $display("FAIL wdog_early got %b want 01", {Error, Busy}); end
    tick();
    checks++; if ({Error, Busy} !== 2'b10) begin errors++; $display("FAIL wdog_expire got %b want 10", {Error, Busy}); end
    load(4'd9, {1'b1, 2'b01, 2'b11, 2'b00, 8'h77});
    pd_kill = 1'b0;
    tick();
    checks++; if (Error !== 1'b1) begin errors++; $display("FAIL wdog_sticky got %b want 1", Error); end
    start(4'd9);
    checks++; if ({Error, w} !== 2'b01) begin errors++; $display("FAIL wdog_restart got %b want 01", {Error, w}); end
    for (int c = 0; c < 10 && Busy; c++) tick();
    checks++; if ({Halted, PC, InstrCount} !== {1'b1, 4'd9, 8'd1}) begin errors++; $display("FAIL wdog_rerun got %b/%0d/%0d want 1/9/1", Halted, PC, InstrCount); end
    checks++; if (R[3] !== 8'h77) begin errors++; $display("FAIL wdog_load got %h want 77", R[3]); end
  endtask

  task automatic test_reset_mid();
    start(4'd2);
    tick(); tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    tick(); tick();
    checks++; if ({Busy, w, Halted} !== 3'b000) begin errors++; $display("FAIL midreset_flags got %b want 000", {Busy, w, Halted}); end
    checks++; if ({PC, InstrCount} !== 12'd0) begin errors++; $display("FAIL midreset_state got %h want 000", {PC, InstrCount}); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 4; i++) begin
      b_LdEn = 1'b1; b_LdAddr = 2'(i); b_LdWord = {1'b0, 2'b01, 2'b00, 2'b00, 8'(i)};
      tick();
    end
    b_LdEn = 1'b0;
    b_Start = 1'b1; b_StartAddr = 2'd3;
    tick();
    b_Start = 1'b0;
    checks++; if ({b_w, b_PC, b_Data} !== {1'b1, 2'd3, 8'd3}) begin errors++; $display("FAIL wrap_pc3 got %b/%0d/%0d want 1/3/3", b_w, b_PC, b_Data); end
    tick(); tick();
    checks++; if ({b_w, b_PC, b_Data} !== {1'b1, 2'd0, 8'd0}) begin errors++; $display("FAIL wrap_pc0 got %b/%0d/%0d want 1/0/0", b_w, b_PC, b_Data); end
    tick(); tick();
    checks++; if ({b_w, b_PC, b_Data} !== {1'b1, 2'd1, 8'd1}) begin errors++; $display("FAIL wrap_pc1 got %b/%0d/%0d want 1/1/1", b_w, b_PC, b_Data); end
    tick();
    b_Abort = 1'b1;
    tick();
    b_Abort = 1'b0;
    checks++; if ({b_Busy, b_Halted, b_PC, b_InstrCount} !== {1'b0, 1'b0, 2'd1, 8'd3}) begin errors++; $display("FAIL wrap_abort got %b%b/%0d/%0d want 00/1/3", b_Busy, b_Halted, b_PC, b_InstrCount); end
  endtask

`ifdef SEQ_STEP_EN
  task automatic test_step();
    load(4'd10, {1'b0, 2'b01, 2'b01, 2'b00, 8'h31});
    load(4'd11, {1'b1, 2'b01, 2'b10, 2'b00, 8'h32});
    start(4'd10);
    Step = 1'b1;
    tick();
    Step = 1'b0;
    tick(); tick();
    checks++; if ({w, Busy, PC} !== {1'b0, 1'b1, 4'd11}) begin errors++; $display("FAIL step_hold got %b%b/%0d want 01/11", w, Busy, PC); end
    Step = 1'b1;
    tick();
    Step = 1'b0;
    checks++; if ({w, Data} !== {1'b1, 8'h32}) begin errors++; $display("FAIL step_issue got %b/%h want 1/32", w, Data); end
    tick(); tick();
    checks++; if ({Halted, R[2]} !== {1'b1, 8'h32}) begin errors++; $display("FAIL step_end got %b/%h want 1/32", Halted, R[2]); end
  endtask
`endif

  initial begin
    Reset = 1'b1; LdEn = 1'b0; LdAddr = '0; LdWord = '0; Start = 1'b0; StartAddr = '0;
    Abort = 1'b0; Step = 1'b0;
    b_LdEn = 1'b0; b_LdAddr = '0; b_LdWord = '0; b_Start = 1'b0; b_StartAddr = '0; b_Abort = 1'b0;
    test_reset();
    test_stop_run();
    test_add_run();
    test_abort();
    test_watchdog();
    test_reset_mid();
    test_wrap();
`ifdef SEQ_STEP_EN
    test_step();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout reached at %0t", $time);
    $fatal(1);
  end

endmodule
